uwire_seq_loader: RTL and testbench
===================================

Name: uwire_seq_loader

Overview:
Parametrised word sequencer that feeds a uWire serializer one word at a time over a ready/start handshake. Generalises the single-shot loader in several ways:
- configurable word width and word count;
- explicit trigger with a snapshot of the input words;
- selectable word order;
- programmable inter-word gap;
- abort, busy and word-index outputs.
Sits between register-file/config logic and the uWire shift engine.

Parameters:
NUM_WORDS, 4, number of words per sequence (>=1)
WORD_W, 32, bits per word (>=1)
GAP_CYCLES, 0, idle cycles inserted after each word's start before the next word may issue (0..255)
MSW_FIRST, 1, 1: issue d[NUM_WORDS-1] first and d[0] last; 0: issue d[0] first
IDX_W, derived = max(1,$clog2(NUM_WORDS)), width of word_idx

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
d  in  [NUM_WORDS-1:0][WORD_W-1:0]  words to send; sampled only on accepted trigger
trigger  in  1  start a sequence; accepted only in IDLE
abort  in  1  terminate sequence; takes effect from any non-IDLE state
ready  in  1  serializer idle / able to accept start
q  out  WORD_W  word presented to serializer; valid when start=1, held until next issue
start  out  1  one-cycle pulse, serializer loads q
done  out  1  one-cycle pulse at sequence completion
busy  out  1  high in every state except IDLE
word_idx  out  IDX_W  index into d of the word currently/last issued

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: q=0, start=0, done=0, busy=0, word_idx=0, state=IDLE, gap counter=0, shadow register=0. Reset mid-sequence behaves identically and emits no done.
- States: IDLE, WAIT_RDY, HOLD, GAP, FIN.
- IDLE: on trigger=1, copy d into shadow, set the remaining count to NUM_WORDS and go to WAIT_RDY. busy=1 from the next cycle. A trigger outside IDLE is ignored, not queued.
- WAIT_RDY: when ready=1, issue the next word:
  - q <= shadow[word_idx_next];
  - start=1 for exactly one cycle;
  - word_idx updated in the same cycle as start;
  - remaining count decremented;
  - go to HOLD.
- Word order: with MSW_FIRST=1 the index sequence is NUM_WORDS-1 down to 0; with MSW_FIRST=0 it is 0 up to NUM_WORDS-1.
- HOLD: one cycle in which ready is ignored, so the serializer can drop ready.
  - GAP_CYCLES>0: go to GAP.
  - Otherwise, if remaining count=0, go to FIN.
  - Otherwise go to WAIT_RDY.
- GAP: count GAP_CYCLES cycles, then go to FIN if remaining count=0, else to WAIT_RDY.
- FIN: wait for ready=1, meaning the last word has finished shifting. Then done=1 for one cycle and go to IDLE. busy falls in the same cycle done pulses.
- Minimum start-to-start spacing: 2+GAP_CYCLES cycles.
- Latency:
  - trigger to first start is 2 cycles when ready is already high;
  - last start to done is at least 2+GAP_CYCLES cycles.
- abort=1 in any non-IDLE state: next cycle is IDLE with start=0 and done=0. q keeps its last value.
  - If abort and the ready condition occur in the same cycle, abort wins and no start is issued.
  - abort in IDLE has no effect.
- Simultaneous trigger and abort in IDLE: trigger is accepted.
- NUM_WORDS=1: a single start, then FIN.
- Changes on d after the trigger cycle do not affect the running sequence.
- Count and gap-counter widths are sized so NUM_WORDS and GAP_CYCLES never wrap.

Optional Feature:
UWIRE_SEQ_LOOP_EN:
- Defined: adds input port loop (1 bit).
  - In FIN with loop=1 and ready=1: done pulses, d is re-snapshotted, the count is reloaded and the state goes to WAIT_RDY. busy stays 1.
  - loop=0 behaves as the base design.
  - abort exits the loop.
- Undefined: no loop port; FIN always returns to IDLE.

Test Plan:
1. NUM_WORDS=3, WORD_W=32, MSW_FIRST=1, GAP=0; d={C,B,A}, ready held 1, trigger at t0 -> starts at t2,t4,t6 with q=C,B,A and word_idx=2,1,0; done at t8.
2. MSW_FIRST=0, WORD_W=16, GAP=3; d={0x3333,0x2222,0x1111}, ready=1 -> q order 0x1111,0x2222,0x3333; starts spaced 5 cycles.
3. Serializer model drops ready for 10 cycles after each start -> exactly one start per ready rising edge; change d mid-sequence -> the originally snapshotted words are sent.
4. abort asserted the cycle after the second start of 4 -> no further start, no done, busy=0 next cycle; a new trigger then restarts from the first word.
5. rst asserted mid-sequence -> all outputs 0 next cycle; a trigger during a busy sequence is ignored (start count stays at NUM_WORDS).
6. UWIRE_SEQ_LOOP_EN with loop=1 for 2 passes, then loop=0 -> 2*NUM_WORDS+NUM_WORDS starts, done pulses 3 times, busy continuous until the final done.

Source files
------------

// File: rtl/uwire_seq_loader.sv
// uwire_seq_loader: snapshots NUM_WORDS words on trigger and hands them one at
// a time to a uWire serializer over a ready/start handshake, with selectable
// word order, a programmable post-start gap, abort, busy and word index.
// Optional build macro UWIRE_SEQ_LOOP_EN adds a 'loop' input that re-arms the
// sequence from FIN without passing through IDLE.
module uwire_seq_loader #(
  parameter int NUM_WORDS  = 4,
  parameter int WORD_W     = 32,
  parameter int GAP_CYCLES = 0,
  parameter bit MSW_FIRST  = 1'b1,
  parameter int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WORDS-1:0][WORD_W-1:0] d,
  input  logic                             trigger,
  input  logic                             abort,
  input  logic                             ready,
`ifdef UWIRE_SEQ_LOOP_EN
  input  logic                             loop,
`endif
  output logic [WORD_W-1:0]                q,
  output logic                             start,
  output logic                             done,
  output logic                             busy,
  output logic [IDX_W-1:0]                 word_idx
);
  // remaining-count and gap-counter widths hold NUM_WORDS / GAP_CYCLES without wrap
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int GCW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, HOLD, GAP, FIN} state_t;

  state_t                           state, state_nx;
  logic [NUM_WORDS-1:0][WORD_W-1:0] shadow;
  logic [CNT_W-1:0]                 rem;
  logic [GCW-1:0]                   gcnt;
  logic [IDX_W-1:0]                 idx_nx;
  logic                             do_load, do_issue, do_done, gap_end, relo;

`ifdef UWIRE_SEQ_LOOP_EN
  assign relo = loop;
`else
  assign relo = 1'b0;
`endif

  assign gap_end = (gcnt == GCW'(GLAST));
  assign busy    = (state != IDLE);

  // index of the next word to issue, derived from how many words remain
  always_comb begin
    if (MSW_FIRST) idx_nx = IDX_W'(int'(rem) - 1);
    else           idx_nx = IDX_W'(NUM_WORDS - int'(rem));
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (trigger) state_nx = WAIT_RDY;
      WAIT_RDY: if (ready) state_nx = HOLD;
      HOLD: begin
        if (GAP_CYCLES > 0)  state_nx = GAP;
        else if (rem == '0)  state_nx = FIN;
        else                 state_nx = WAIT_RDY;
      end
      GAP:      if (gap_end) state_nx = (rem == '0) ? FIN : WAIT_RDY;
      FIN:      if (ready) state_nx = relo ? WAIT_RDY : IDLE;
      default:  state_nx = IDLE;
    endcase
    if (abort && state != IDLE) state_nx = IDLE;
  end

  // output strobes: load snapshot, issue a word, signal completion
  always_comb begin
    do_load  = 1'b0;
    do_issue = 1'b0;
    do_done  = 1'b0;
    case (state)
      IDLE:     do_load  = trigger;
      WAIT_RDY: do_issue = ready && !abort;
      FIN: begin
        do_done = ready && !abort;
        do_load = ready && !abort && relo;
      end
      default: ;
    endcase
  end

  // datapath: snapshot, word issue, remaining count, gap counter, pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      rem      <= '0;
      gcnt     <= '0;
      q        <= '0;
      word_idx <= '0;
      start    <= 1'b0;
      done     <= 1'b0;
    end else begin
      start <= do_issue;
      done  <= do_done;
      if (do_load) begin
        shadow <= d;
        rem    <= CNT_W'(NUM_WORDS);
      end
      if (do_issue) begin
        q        <= shadow[idx_nx];
        word_idx <= idx_nx;
        rem      <= rem - 1'b1;
      end
      if (state == GAP && !gap_end) gcnt <= gcnt + 1'b1;
      else                          gcnt <= '0;
    end
  end
endmodule

// File: tb/tb_uwire_seq_loader.sv
// Bench for uwire_seq_loader: two instances (3x32 MSW-first no gap, 4x16
// LSW-first gap 3) checked every cycle against a timing-rule reference model,
// plus a vector table and directed multi-cycle sequences.
module tb_uwire_seq_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NW   [2] = '{3, 4};
  localparam int GAPC [2] = '{0, 3};
  localparam bit MSWF [2] = '{1'b1, 1'b0};

  logic              rst;
  logic [2:0][31:0]  d0;
  logic [3:0][15:0]  d1;
  logic              trg [2], abt [2], rdy [2], lpv [2];
  logic [31:0]       q0;
  logic [15:0]       q1;
  logic [1:0]        ix0, ix1;
  logic              st [2], dn [2], bz [2];

  uwire_seq_loader #(.NUM_WORDS(3), .WORD_W(32), .GAP_CYCLES(0), .MSW_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .d(d0), .trigger(trg[0]), .abort(abt[0]), .ready(rdy[0]),
`ifdef UWIRE_SEQ_LOOP_EN
    .loop(lpv[0]),
`endif
    .q(q0), .start(st[0]), .done(dn[0]), .busy(bz[0]), .word_idx(ix0));

  uwire_seq_loader #(.NUM_WORDS(4), .WORD_W(16), .GAP_CYCLES(3), .MSW_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .d(d1), .trigger(trg[1]), .abort(abt[1]), .ready(rdy[1]),
`ifdef UWIRE_SEQ_LOOP_EN
    .loop(lpv[1]),
`endif
    .q(q1), .start(st[1]), .done(dn[1]), .busy(bz[1]), .word_idx(ix1));

  // ---------------- reference model (timing rules, not states) ----------------
  // A sequence is "active" from trigger to done/abort. A start or done happens
  // the cycle after a cycle with ready=1 whose index is >= elig; after each
  // start the next eligible ready cycle is 2+GAP later.
  int          mcyc = 0;
  bit          act [2] = '{0, 0};
  bit          es [2] = '{0, 0};
  bit          ed [2] = '{0, 0};
  logic [31:0] eq [2] = '{0, 0};
  int          ei [2] = '{0, 0};
  int          elig [2] = '{0, 0};
  int          pos [2] = '{0, 0};
  logic [31:0] mw [2][4];
  int          mi [2][4];

  function automatic logic [31:0] dword(int k, int i);
    if (k == 0) return d0[i];
    return {16'h0, d1[i]};
  endfunction

  task automatic snap(int k);
    for (int j = 0; j < NW[k]; j++) begin
      int i;
      i = MSWF[k] ? NW[k] - 1 - j : j;
      mw[k][j] = dword(k, i);
      mi[k][j] = i;
    end
    pos[k] = 0;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      es[k] = 1'b0;
      ed[k] = 1'b0;
      if (rst) begin
        act[k] = 1'b0; eq[k] = '0; ei[k] = 0;
      end else if (!act[k]) begin
        if (trg[k]) begin act[k] = 1'b1; snap(k); elig[k] = mcyc + 1; end
      end else if (abt[k]) begin
        act[k] = 1'b0;
      end else if (mcyc >= elig[k] && rdy[k]) begin
        if (pos[k] < NW[k]) begin
          es[k] = 1'b1; eq[k] = mw[k][pos[k]]; ei[k] = mi[k][pos[k]];
          pos[k]++; elig[k] = mcyc + 2 + GAPC[k];
        end else begin
          ed[k] = 1'b1;
          if (lpv[k]) begin snap(k); elig[k] = mcyc + 1; end
          else act[k] = 1'b0;
        end
      end
    end
    mcyc++;
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;
  int ns [2] = '{0, 0};
  int ndn [2] = '{0, 0};
  logic [31:0] gq0[$], gq1[$];
  int sc1[$];
  bit busy_gap;

  task automatic cmp(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, mcyc, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp("start0", 64'(st[0]), 64'(es[0]));
    cmp("done0",  64'(dn[0]), 64'(ed[0]));
    cmp("busy0",  64'(bz[0]), 64'(act[0]));
    cmp("q0",     64'(q0),    64'(eq[0]));
    cmp("idx0",   64'(ix0),   64'(ei[0]));
    cmp("start1", 64'(st[1]), 64'(es[1]));
    cmp("done1",  64'(dn[1]), 64'(ed[1]));
    cmp("busy1",  64'(bz[1]), 64'(act[1]));
    cmp("q1",     64'(q1),    64'(eq[1]));
    cmp("idx1",   64'(ix1),   64'(ei[1]));
    if (st[0]) begin ns[0]++; gq0.push_back(q0); end
    if (st[1]) begin ns[1]++; gq1.push_back({16'h0, q1}); sc1.push_back(mcyc); end
    if (dn[0]) ndn[0]++;
    if (dn[1]) ndn[1]++;
  endtask

  typedef struct {
    bit          trig;
    bit          rd;
    bit          s;
    logic [31:0] q;
    int          ix;
    bit          dn;
    bit          bz;
  } vec_t;
  vec_t tv [9];

  localparam logic [31:0] WA = 32'hAAAA_0001, WB = 32'hBBBB_0002, WC = 32'hCCCC_0003;

  initial begin
    int base, hold, n0;
    logic [2:0][31:0] keep;

    // row r: inputs during cycle r, outputs expected in cycle r+1
    tv[0] = '{1, 1, 0, 32'h0, 0, 0, 1};
    tv[1] = '{0, 1, 1, WC,    2, 0, 1};
    tv[2] = '{0, 1, 0, WC,    2, 0, 1};
    tv[3] = '{0, 1, 1, WB,    1, 0, 1};
    tv[4] = '{0, 1, 0, WB,    1, 0, 1};
    tv[5] = '{0, 1, 1, WA,    0, 0, 1};
    tv[6] = '{0, 1, 0, WA,    0, 0, 1};
    tv[7] = '{0, 1, 0, WA,    0, 1, 0};
    tv[8] = '{0, 1, 0, WA,    0, 0, 0};

    rst = 1'b1; d0 = '0; d1 = '0;
    for (int k = 0; k < 2; k++) begin trg[k] = 0; abt[k] = 0; rdy[k] = 0; lpv[k] = 0; end
    repeat (3) tick();
    cmp("rst_q0", 64'(q0), 64'd0);
    cmp("rst_busy0", 64'(bz[0]), 64'd0);
    cmp("rst_idx1", 64'(ix1), 64'd0);
    rst = 1'b0;

    // test 1: vector table, 3 words MSW first, no gap
    d0 = {WC, WB, WA};
    for (int r = 0; r < 9; r++) begin
      trg[0] = tv[r].trig; rdy[0] = tv[r].rd;
      tick();
      cmp($sformatf("t1_start[%0d]", r), 64'(st[0]), 64'(tv[r].s));
      cmp($sformatf("t1_q[%0d]", r),     64'(q0),    64'(tv[r].q));
      cmp($sformatf("t1_idx[%0d]", r),   64'(ix0),   64'(tv[r].ix));
      cmp($sformatf("t1_done[%0d]", r),  64'(dn[0]), 64'(tv[r].dn));
      cmp($sformatf("t1_busy[%0d]", r),  64'(bz[0]), 64'(tv[r].bz));
    end
    trg[0] = 0; rdy[0] = 0;

    // test 2: LSW first, gap 3 -> ascending order, 5-cycle spacing
    d1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    gq1.delete(); sc1.delete(); base = ndn[1];
    rdy[1] = 1; trg[1] = 1; tick(); trg[1] = 0;
    for (int t = 0; t < 100 && ndn[1] == base; t++) tick();
    cmp("t2_done", 64'(ndn[1] - base), 64'd1);
    cmp("t2_nstart", 64'(gq1.size()), 64'd4);
    if (gq1.size() == 4)
      for (int i = 0; i < 4; i++) begin
        cmp($sformatf("t2_word%0d", i), 64'(gq1[i]), 64'(32'h1111 * (i + 1)));
        if (i > 0) cmp($sformatf("t2_gap%0d", i), 64'(sc1[i] - sc1[i-1]), 64'd5);
      end
    rdy[1] = 0;

    // test 3: serializer drops ready 10 cycles after each start; d changes mid-run
    d0 = {32'h3030_3030, 32'h2020_2020, 32'h1010_1010}; keep = d0;
    gq0.delete(); base = ndn[0]; hold = 0;
    rdy[0] = 1; trg[0] = 1; tick(); trg[0] = 0;
    for (int t = 0; t < 300 && ndn[0] == base; t++) begin
      if (st[0]) begin hold = 10; d0 = {$urandom, $urandom, $urandom}; end
      rdy[0] = (hold == 0);
      if (hold > 0) hold--;
      tick();
    end
    cmp("t3_done", 64'(ndn[0] - base), 64'd1);
    cmp("t3_nstart", 64'(gq0.size()), 64'd3);
    if (gq0.size() == 3)
      for (int i = 0; i < 3; i++) cmp($sformatf("t3_word%0d", i), 64'(gq0[i]), 64'(keep[2-i]));
    rdy[0] = 0;

    // test 4: abort the cycle after the 2nd of 4 starts, then restart
    d1 = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    base = ns[1]; n0 = ndn[1];
    rdy[1] = 1; trg[1] = 1; tick(); trg[1] = 0;
    for (int t = 0; t < 50 && ns[1] - base < 2; t++) tick();
    cmp("t4_two_starts", 64'(ns[1] - base), 64'd2);
    tick();
    abt[1] = 1; tick(); abt[1] = 0;
    cmp("t4_busy_after_abort", 64'(bz[1]), 64'd0);
    repeat (30) tick();
    cmp("t4_no_more_start", 64'(ns[1] - base), 64'd2);
    cmp("t4_no_done", 64'(ndn[1] - n0), 64'd0);
    base = ns[1];
    trg[1] = 1; tick(); trg[1] = 0;
    for (int t = 0; t < 20 && ns[1] == base; t++) tick();
    cmp("t4_restart_q", 64'(q1), 64'h0000_AAAA);
    cmp("t4_restart_idx", 64'(ix1), 64'd0);
    for (int t = 0; t < 100 && bz[1]; t++) tick();
    rdy[1] = 0;

    // test 5: trigger while busy is ignored; reset mid-sequence clears outputs
    d0 = {WA, WB, WC}; base = ns[0]; n0 = ndn[0];
    rdy[0] = 1; trg[0] = 1; tick(); trg[0] = 0;
    repeat (3) tick();
    trg[0] = 1; tick(); trg[0] = 0;
    for (int t = 0; t < 50 && ndn[0] == n0; t++) tick();
    repeat (4) tick();
    cmp("t5_start_count", 64'(ns[0] - base), 64'd3);
    trg[0] = 1; tick(); trg[0] = 0;
    repeat (2) tick();
    n0 = ndn[0];
    rst = 1; tick(); rst = 0;
    cmp("t5_rst_start", 64'(st[0]), 64'd0);
    cmp("t5_rst_busy", 64'(bz[0]), 64'd0);
    cmp("t5_rst_q", 64'(q0), 64'd0);
    cmp("t5_rst_idx", 64'(ix0), 64'd0);
    repeat (20) tick();
    cmp("t5_no_done_after_rst", 64'(ndn[0] - n0), 64'd0);

`ifdef UWIRE_SEQ_LOOP_EN
    // test 6: two looped passes then a final pass
    base = ns[0]; n0 = ndn[0]; busy_gap = 0;
    rdy[0] = 1; lpv[0] = 1; trg[0] = 1; tick(); trg[0] = 0;
    for (int t = 0; t < 200 && ndn[0] - n0 < 3; t++) begin
      if (ndn[0] - n0 >= 2) lpv[0] = 0;
      if (!bz[0] && ndn[0] - n0 < 3) busy_gap = 1;
      tick();
    end
    cmp("t6_starts", 64'(ns[0] - base), 64'd9);
    cmp("t6_dones", 64'(ndn[0] - n0), 64'd3);
    cmp("t6_busy_cont", 64'(busy_gap), 64'd0);
    lpv[0] = 0;
`endif

    // randomized traffic against the reference model
    for (int t = 0; t < 2000; t++) begin
      for (int k = 0; k < 2; k++) begin
        trg[k] = ($urandom % 8) == 0;
        abt[k] = ($urandom % 40) == 0;
        rdy[k] = ($urandom % 3) != 0;
`ifdef UWIRE_SEQ_LOOP_EN
        lpv[k] = ($urandom % 4) == 0;
`endif
      end
      if (($urandom % 5) == 0) begin d0 = {$urandom, $urandom, $urandom}; d1 = {$urandom, $urandom}; end
      rst = ($urandom % 300) == 0;
      tick();
    end
    rst = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
